l2_bank_rr_arbiter: RTL and testbench
=====================================

Name: l2_bank_rr_arbiter

Overview:
- Sits directly upstream of one interleaved L2 FPGA block-RAM bank.
- Arbitrates N TCDM-style master ports (req/gnt request, r_valid response) onto the bank's single-port interface: csn/wen/be/addr/wdata in, rdata out.
- Arbitration is round-robin. The block tracks which master owns the in-flight access and returns rdata/r_valid to that master one cycle after the grant, matching the bank's 1-cycle registered read latency.

Parameters:
- N_MASTERS, 2, number of master ports; legal range 2..8.
- ADDR_WIDTH, 12, bank word-address width; must equal the bank's address width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- m_req_i  input  N_MASTERS  per-master request.
- m_wen_i  input  N_MASTERS  per-master write enable, active-low (0 = write).
- m_be_i  input  N_MASTERS*4  per-master byte enables, master i in bits [4i+3:4i].
- m_addr_i  input  N_MASTERS*ADDR_WIDTH  per-master word address.
- m_wdata_i  input  N_MASTERS*32  per-master write data.
- m_gnt_o  output  N_MASTERS  per-master grant, one-hot or zero.
- m_r_valid_o  output  N_MASTERS  per-master response valid.
- m_r_rdata_o  output  32  read data, shared by all masters; meaningful only with m_r_valid_o.
- bank_csn_o  output  1  bank chip select, active-low.
- bank_wen_o  output  1  bank write enable, active-low.
- bank_be_o  output  4  bank byte enables.
- bank_addr_o  output  ADDR_WIDTH  bank address.
- bank_wdata_o  output  32  bank write data.
- bank_rdata_i  input  32  bank read data, valid one cycle after an enabled access.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - Round-robin pointer ptr=0.
  - Response owner register cleared; m_r_valid_o=0.
  - Combinational outputs follow the rules below with req sampled normally.
- Grant (combinational):
  - Winner = first i with m_req_i[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N_MASTERS.
  - m_gnt_o[winner]=1; all other bits 0. If no request, m_gnt_o=0.
  - A master holds req and its payload until it sees gnt; the payload may change after gnt.
- Bank drive (combinational, same cycle as grant):
  - Any grant: bank_csn_o=0; bank_wen_o, bank_be_o, bank_addr_o, bank_wdata_o = the winner's fields.
  - No grant: bank_csn_o=1, bank_wen_o=1, bank_be_o=0, bank_addr_o=0, bank_wdata_o=0.
- Pointer update (registered):
  - On a grant, ptr <= (winner+1) mod N_MASTERS.
  - With no grant, ptr holds.
  - The pointer wraps from N_MASTERS-1 to 0.
- Response (registered, latency exactly 1):
  - The cycle after a grant to master i, m_r_valid_o[i]=1 for one cycle; all other bits 0.
  - This applies to reads and writes alike; a write response carries don't-care data.
  - m_r_rdata_o = bank_rdata_i unconditionally (pass-through, not registered).
- Throughput: one access per cycle. Back-to-back grants produce back-to-back r_valid pulses, each routed to its own owner.
- Simultaneous grant and response: the response for cycle t-1 and the grant for cycle t are independent. The same master may be granted in consecutive cycles only when it is the sole requester.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0,...; each master waits at most N_MASTERS-1 cycles.
- Reset mid-operation: a pending response is dropped (m_r_valid_o=0 immediately on rst_ni=0) and ptr returns to 0. No bank access is issued while req=0.
- Width rule: ptr and the owner index are $clog2(N_MASTERS) bits wide. An owner-valid flag is kept separately, so index 0 is not mistaken for "no owner".

Test Plan:
- Reset, then single read: M0 writes 0xDEADBEEF to addr 0x010 (be=0xF); in a later cycle M0 reads 0x010 -> gnt same cycle as req; m_r_valid_o=01 exactly one cycle later with rdata 0xDEADBEEF; bank_csn_o=1 when idle.
- Byte-enable write: M1 writes 0x11223344 with be=0x3 over existing 0xAAAAAAAA at 0x020; M1 then reads 0x020 -> rdata 0xAAAA3344; bank_be_o=0x3 during the write grant.
- Contention, N=2: M0 and M1 request every cycle from reset -> gnt sequence 01,10,01,10; r_valid sequence lags by one cycle with identical pattern; no cycle has bank_csn_o=1.
- Pointer wrap, N=4: only M3 requests (grant), then M0 and M2 request together -> M0 granted first (ptr wrapped to 0), M2 next cycle.
- Reset mid-access: grant M1 in cycle t, assert rst_ni=0 before the edge ending cycle t -> m_r_valid_o stays 0; after release, M1 and M0 request together -> M0 granted (ptr=0).
- Idle gaps: M1 requests in cycles 0, 3, 4 only -> exactly three r_valid pulses at cycles 1, 4, 5; bank outputs zeroed with csn=1 in cycles 1 and 2.

Source files
------------

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter that places N TCDM-style masters onto one single-port L2 bank.
// It routes the 1-cycle-latency response back to the master that owned the access.
module l2_bank_rr_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_MASTERS-1:0]            m_req_i,
    input  logic [N_MASTERS-1:0]            m_wen_i,
    input  logic [N_MASTERS*4-1:0]          m_be_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [N_MASTERS*32-1:0]         m_wdata_i,
    output logic [N_MASTERS-1:0]            m_gnt_o,
    output logic [N_MASTERS-1:0]            m_r_valid_o,
    output logic [31:0]                     m_r_rdata_o,
    output logic                            bank_csn_o,
    output logic                            bank_wen_o,
    output logic [3:0]                      bank_be_o,
    output logic [ADDR_WIDTH-1:0]           bank_addr_o,
    output logic [31:0]                     bank_wdata_o,
    input  logic [31:0]                     bank_rdata_i
);

    localparam int IDX_W = $clog2(N_MASTERS);
    typedef logic [IDX_W-1:0] idx_t;

    logic [3:0]            be_arr    [N_MASTERS];
    logic [ADDR_WIDTH-1:0] addr_arr  [N_MASTERS];
    logic [31:0]           wdata_arr [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign be_arr[gi]    = m_be_i[gi*4 +: 4];
            assign addr_arr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = m_wdata_i[gi*32 +: 32];
        end
    endgenerate

    idx_t           ptr_q, ptr_d;
    idx_t           owner_idx_q, owner_idx_d;
    logic           owner_vld_q, owner_vld_d;
    idx_t           winner;
    logic           gnt_any;
    logic [IDX_W:0] cand;

    // Scan from ptr upward; cand carries one extra bit so the modulo wrap is exact for any N.
    always_comb begin
        winner  = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (!gnt_any && m_req_i[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                winner  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        m_gnt_o      = '0;
        bank_csn_o   = 1'b1;
        bank_wen_o   = 1'b1;
        bank_be_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        if (gnt_any) begin
            m_gnt_o[winner] = 1'b1;
            bank_csn_o      = 1'b0;
            bank_wen_o      = m_wen_i[winner];
            bank_be_o       = be_arr[winner];
            bank_addr_o     = addr_arr[winner];
            bank_wdata_o    = wdata_arr[winner];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_vld_d = gnt_any;
        owner_idx_d = winner;
        if (gnt_any) begin
            ptr_d = (winner == idx_t'(N_MASTERS-1)) ? '0 : winner + idx_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            owner_idx_q <= '0;
            owner_vld_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            owner_idx_q <= owner_idx_d;
            owner_vld_q <= owner_vld_d;
        end
    end

    // Separate valid flag keeps owner index 0 distinct from "no access in flight".
    always_comb begin
        m_r_valid_o = '0;
        if (owner_vld_q) begin
            m_r_valid_o[owner_idx_q] = 1'b1;
        end
    end

    assign m_r_rdata_o = bank_rdata_i;

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Bench for l2_bank_rr_arbiter: three instances (2, 4 and 3 masters) share one stimulus,
// a per-cycle model check, and directed literal checks; instance 0 drives a modelled bank.
module tb_l2_bank_rr_arbiter;

    localparam int NI = 3;
    localparam int AW = 12;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          req;
    logic [7:0]          wen_v;
    logic [31:0]         be_v;
    logic [8*AW-1:0]     addr_v;
    logic [255:0]        wdata_v;
    logic [31:0]         bank_q;
    logic [31:0]         rdata_pat = 32'h5A5A0000;
    logic [31:0]         mem [4096];
    logic                chk_en = 1'b0;

    logic [NI-1:0][7:0]  gnt_a;
    logic [NI-1:0][7:0]  rv_a;
    logic [NI-1:0]       csn_a;
    logic [NI-1:0]       wen_a;
    logic [NI-1:0][3:0]  be_a;
    logic [NI-1:0][AW-1:0] addr_a;
    logic [NI-1:0][31:0] wdata_a;
    logic [NI-1:0][31:0] rdata_a;
    logic [NI-1:0][31:0] rin_a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int nm_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 3);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int NM = (gi == 0) ? 2 : ((gi == 1) ? 4 : 3);
            logic [NM-1:0] gnt;
            logic [NM-1:0] rv;
            assign rin_a[gi] = (gi == 0) ? bank_q : rdata_pat;
            assign gnt_a[gi] = 8'(gnt);
            assign rv_a[gi]  = 8'(rv);
            l2_bank_rr_arbiter #(.N_MASTERS(NM), .ADDR_WIDTH(AW)) u_dut (
                .clk_i        (clk),
                .rst_ni       (rst_n),
                .m_req_i      (req[NM-1:0]),
                .m_wen_i      (wen_v[NM-1:0]),
                .m_be_i       (be_v[NM*4-1:0]),
                .m_addr_i     (addr_v[NM*AW-1:0]),
                .m_wdata_i    (wdata_v[NM*32-1:0]),
                .m_gnt_o      (gnt),
                .m_r_valid_o  (rv),
                .m_r_rdata_o  (rdata_a[gi]),
                .bank_csn_o   (csn_a[gi]),
                .bank_wen_o   (wen_a[gi]),
                .bank_be_o    (be_a[gi]),
                .bank_addr_o  (addr_a[gi]),
                .bank_wdata_o (wdata_a[gi]),
                .bank_rdata_i (rin_a[gi])
            );
        end
    endgenerate

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // First requesting master found scanning p, p+1, ... modulo n; -1 if none.
    function automatic int pick(int n, int p, logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            if (r[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    // Bank with 1-cycle registered read, byte-masked write.
    always @(posedge clk) begin
        rdata_pat <= rdata_pat + 32'h01000193;
        if (!csn_a[0]) begin
            if (!wen_a[0]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_a[0][b]) mem[addr_a[0]][8*b +: 8] <= wdata_a[0][8*b +: 8];
                end
            end else begin
                bank_q <= mem[addr_a[0]];
            end
        end
    end

    // Model state: next-priority master and the master whose response is due (-1 = none).
    int ptr_m [NI] = '{0, 0, 0};
    int own_m [NI] = '{-1, -1, -1};
    int w_m;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                ptr_m[i] <= 0;
                own_m[i] <= -1;
            end else begin
                w_m = pick(nm_of(i), ptr_m[i], req);
                own_m[i] <= w_m;
                if (w_m >= 0) ptr_m[i] <= (w_m + 1) % nm_of(i);
            end
        end
    end

    int w_c;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                w_c = pick(nm_of(i), ptr_m[i], req);
                chk($sformatf("i%0d gnt", i), 64'(gnt_a[i]), (w_c < 0) ? 64'd0 : 64'd1 << w_c);
                chk($sformatf("i%0d csn", i), 64'(csn_a[i]), (w_c < 0) ? 64'd1 : 64'd0);
                chk($sformatf("i%0d wen", i), 64'(wen_a[i]), (w_c < 0) ? 64'd1 : 64'(wen_v[w_c]));
                chk($sformatf("i%0d be", i), 64'(be_a[i]), (w_c < 0) ? 64'd0 : 64'(be_v[w_c*4 +: 4]));
                chk($sformatf("i%0d addr", i), 64'(addr_a[i]), (w_c < 0) ? 64'd0 : 64'(addr_v[w_c*AW +: AW]));
                chk($sformatf("i%0d wdata", i), 64'(wdata_a[i]), (w_c < 0) ? 64'd0 : 64'(wdata_v[w_c*32 +: 32]));
                chk($sformatf("i%0d rvalid", i), 64'(rv_a[i]), (own_m[i] < 0) ? 64'd0 : 64'd1 << own_m[i]);
                chk($sformatf("i%0d rdata", i), 64'(rdata_a[i]), 64'(rin_a[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_m(int m, logic w, logic [3:0] b, logic [AW-1:0] a, logic [31:0] d);
        wen_v[m]            = w;
        be_v[4*m +: 4]      = b;
        addr_v[m*AW +: AW]  = a;
        wdata_v[32*m +: 32] = d;
    endtask

    logic [7:0] pats [16] = '{8'h05, 8'h0A, 8'h0F, 8'h00, 8'h06, 8'h09, 8'h03, 8'h0C,
                              8'h07, 8'h0E, 8'h01, 8'h08, 8'h0B, 8'h0D, 8'h02, 8'h04};
    logic [7:0] cont_gnt [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
    logic [7:0] cont_rv  [4] = '{8'h00, 8'h01, 8'h02, 8'h01};
    logic [7:0] fair4    [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02};
    logic [7:0] fair3    [6] = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
    logic       idle_req [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] idle_rv  [7] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int m = 0; m < 8; m++) begin
            set_m(m, m[0], 4'(m + 1), AW'(12'h100 + 16 * m), 32'hC0DE0000 | 32'(m));
        end
        chk_en = 1'b1;
        step();
        step();
        at_neg();
        chk("reset rvalid", 64'(rv_a[0]), 64'd0);
        chk("reset gnt", 64'(gnt_a[0]), 64'd0);
        chk("reset csn", 64'(csn_a[0]), 64'd1);
        step();
        rst_n = 1'b1;

        // M0 write then read back
        set_m(0, 1'b0, 4'hF, 12'h010, 32'hDEADBEEF);
        req = 8'h01;
        at_neg();
        chk("wr gnt", 64'(gnt_a[0]), 64'h01);
        chk("wr wen", 64'(wen_a[0]), 64'd0);
        step();
        req = 8'h00;
        at_neg();
        chk("wr rvalid", 64'(rv_a[0]), 64'h01);
        chk("idle csn", 64'(csn_a[0]), 64'd1);
        step();
        set_m(0, 1'b1, 4'hF, 12'h010, 32'h0);
        req = 8'h01;
        at_neg();
        chk("rd gnt", 64'(gnt_a[0]), 64'h01);
        step();
        req = 8'h00;
        at_neg();
        chk("rd rvalid", 64'(rv_a[0]), 64'h01);
        chk("rd rdata", 64'(rdata_a[0]), 64'hDEADBEEF);
        step();
        at_neg();
        chk("rd rvalid one pulse", 64'(rv_a[0]), 64'h00);

        // M1 partial byte-enable write
        step();
        set_m(1, 1'b0, 4'hF, 12'h020, 32'hAAAAAAAA);
        req = 8'h02;
        at_neg();
        chk("be fill gnt", 64'(gnt_a[0]), 64'h02);
        step();
        set_m(1, 1'b0, 4'h3, 12'h020, 32'h11223344);
        at_neg();
        chk("be write be", 64'(be_a[0]), 64'h3);
        step();
        set_m(1, 1'b1, 4'hF, 12'h020, 32'h0);
        at_neg();
        step();
        req = 8'h00;
        at_neg();
        chk("be rvalid", 64'(rv_a[0]), 64'h02);
        chk("be rdata", 64'(rdata_a[0]), 64'hAAAA3344);

        // Contention from reset
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 8'h03;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk($sformatf("cont gnt c%0d", k), 64'(gnt_a[0]), 64'(cont_gnt[k]));
            chk($sformatf("cont rvalid c%0d", k), 64'(rv_a[0]), 64'(cont_rv[k]));
            chk($sformatf("cont csn c%0d", k), 64'(csn_a[0]), 64'd0);
            chk($sformatf("cont n4 gnt c%0d", k), 64'(gnt_a[1]), 64'(cont_gnt[k]));
            step();
        end

        // Pointer wrap on the 4-master instance
        rst_n = 1'b0;
        req = 8'h00;
        step();
        rst_n = 1'b1;
        req = 8'h08;
        at_neg();
        chk("wrap gnt m3", 64'(gnt_a[1]), 64'h08);
        step();
        req = 8'h05;
        at_neg();
        chk("wrap gnt m0", 64'(gnt_a[1]), 64'h01);
        step();
        req = 8'h04;
        at_neg();
        chk("wrap gnt m2", 64'(gnt_a[1]), 64'h04);
        step();
        req = 8'h00;

        // Reset before the edge that ends the grant cycle
        step();
        req = 8'h02;
        at_neg();
        chk("rst gnt m1", 64'(gnt_a[0]), 64'h02);
        #2 rst_n = 1'b0;
        #1 chk("rst rvalid pre", 64'(rv_a[0]), 64'h00);
        step();
        chk("rst rvalid held", 64'(rv_a[0]), 64'h00);
        rst_n = 1'b1;
        req = 8'h03;
        at_neg();
        chk("rst ptr0 gnt", 64'(gnt_a[0]), 64'h01);
        step();
        req = 8'h02;
        at_neg();
        step();
        req = 8'h00;
        at_neg();
        chk("async pre rvalid", 64'(rv_a[0]), 64'h02);
        #2 rst_n = 1'b0;
        #1 chk("async drop rvalid", 64'(rv_a[0]), 64'h00);
        step();
        rst_n = 1'b1;

        // Idle gaps
        set_m(1, 1'b1, 4'hF, 12'h030, 32'h0);
        for (int k = 0; k < 7; k++) begin
            req = idle_req[k] ? 8'h02 : 8'h00;
            at_neg();
            chk($sformatf("idle rvalid c%0d", k), 64'(rv_a[0]), 64'(idle_rv[k]));
            chk($sformatf("idle csn c%0d", k), 64'(csn_a[0]), idle_req[k] ? 64'd0 : 64'd1);
            if (!idle_req[k]) begin
                chk($sformatf("idle addr c%0d", k), 64'(addr_a[0]), 64'd0);
                chk($sformatf("idle be c%0d", k), 64'(be_a[0]), 64'd0);
            end
            step();
        end

        // Fairness with every master requesting
        rst_n = 1'b0;
        req = 8'h00;
        step();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk($sformatf("fair n4 c%0d", k), 64'(gnt_a[1]), 64'(fair4[k]));
            chk($sformatf("fair n3 c%0d", k), 64'(gnt_a[2]), 64'(fair3[k]));
            step();
        end

        // Mixed request patterns, checked against the model only
        for (int k = 0; k < 16; k++) begin
            req = pats[k];
            for (int m = 0; m < 4; m++) begin
                set_m(m, k[0] ^ m[0], 4'(k + m), AW'(12'h200 + 8 * k + m), 32'(k * 256 + m));
            end
            step();
        end
        req = 8'h00;
        step();
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
